// File: rtl/inertial_delay_filter.sv
// Cycle-based inertial delay for one synchronous control bit: dout only follows
// din once the new level has been sampled on DELAY consecutive clock edges.
module inertial_delay_filter #(
    parameter int          DELAY = 4,
    parameter logic        INIT  = 1'b0,
    parameter int unsigned GW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          din,
    input  logic          clr_cnt,
    output logic          dout,
    output logic          pending,
    output logic          glitch,
    output logic [7:0]    glitch_len,
    output logic [GW-1:0] glitch_cnt,
    output logic          dbg_state
);

    generate
        if (DELAY < 1 || DELAY > 255) begin : g_bad_delay
            $error("inertial_delay_filter: DELAY must be in 1..255");
        end
    endgenerate

    // Handshake-free block: din is sampled on every rising edge, all outputs
    // are registered and change only on that edge or on asynchronous reset.

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    localparam logic [7:0]    LAST    = 8'(DELAY - 1);
    localparam logic [GW-1:0] CNT_MAX = '1;

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          dout_q, dout_d;
    logic          glitch_q, glitch_d;
    logic [7:0]    glitch_len_q, glitch_len_d;
    logic [GW-1:0] glitch_cnt_q, glitch_cnt_d;
    logic [GW-1:0] cnt_base;
    logic          differs;

    assign differs = (din != dout_q);
    // A same-cycle clear wins first, so a coincident glitch then counts as one.
    assign cnt_base = clr_cnt ? '0 : glitch_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            dout_q       <= INIT;
            glitch_q     <= 1'b0;
            glitch_len_q <= 8'd0;
            glitch_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            glitch_q     <= glitch_d;
            glitch_len_q <= glitch_len_d;
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dout_d       = dout_q;
        glitch_d     = 1'b0;
        glitch_len_d = glitch_len_q;
        glitch_cnt_d = cnt_base;

        if (!en) begin
            // Bypass: plain register, any candidate is dropped without a report.
            dout_d  = din;
            state_d = IDLE;
            cnt_d   = 8'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (differs) begin
                        if (DELAY == 1) begin
                            dout_d = din;
                        end else begin
                            state_d = PEND;
                            cnt_d   = 8'd1;
                        end
                    end
                end
                PEND: begin
                    if (differs) begin
                        if (cnt_q == LAST) begin
                            dout_d  = din;
                            cnt_d   = 8'd0;
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end else begin
                        // The candidate level died before maturing.
                        state_d      = IDLE;
                        cnt_d        = 8'd0;
                        glitch_d     = 1'b1;
                        glitch_len_d = cnt_q;
                        if (cnt_base != CNT_MAX) begin
                            glitch_cnt_d = cnt_base + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    assign dout       = dout_q;
    assign pending    = (state_q == PEND);
    assign glitch     = glitch_q;
    assign glitch_len = glitch_len_q;
    assign glitch_cnt = glitch_cnt_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_inertial_delay_filter.sv
// Bench for inertial_delay_filter: three instances (DELAY=4/GW=8, DELAY=4/GW=2,
// DELAY=1/INIT=1) share one stimulus and are checked against a run-length model.
module tb_inertial_delay_filter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic din = 1'b0;
  logic clr_cnt = 1'b0;

  logic       o_dout[3];
  logic       o_pend[3];
  logic       o_glitch[3];
  logic       o_dbg[3];
  logic [7:0] o_glen[3];
  logic [7:0] a_gcnt;
  logic [1:0] b_gcnt;
  logic [7:0] c_gcnt;

  int n_checks = 0;
  int n_errors = 0;

  // clock / reset block
  always #5 clk = ~clk;

  inertial_delay_filter #(.DELAY(4), .INIT(1'b0), .GW(8)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .clr_cnt(clr_cnt),
    .dout(o_dout[0]), .pending(o_pend[0]), .glitch(o_glitch[0]),
    .glitch_len(o_glen[0]), .glitch_cnt(a_gcnt), .dbg_state(o_dbg[0])
  );

  inertial_delay_filter #(.DELAY(4), .INIT(1'b0), .GW(2)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .clr_cnt(clr_cnt),
    .dout(o_dout[1]), .pending(o_pend[1]), .glitch(o_glitch[1]),
    .glitch_len(o_glen[1]), .glitch_cnt(b_gcnt), .dbg_state(o_dbg[1])
  );

  inertial_delay_filter #(.DELAY(1), .INIT(1'b1), .GW(8)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .clr_cnt(clr_cnt),
    .dout(o_dout[2]), .pending(o_pend[2]), .glitch(o_glitch[2]),
    .glitch_len(o_glen[2]), .glitch_cnt(c_gcnt), .dbg_state(o_dbg[2])
  );

  // Model: count how long din has differed from dout; a run reaching DELAY
  // moves dout, a run that ends early is a glitch of that length.
  int m_delay[3] = '{4, 4, 1};
  int m_gmax[3]  = '{255, 3, 255};
  bit m_init[3]  = '{1'b0, 1'b0, 1'b1};
  bit m_dout[3];
  bit m_glitch[3];
  int m_run[3];
  int m_glen[3];
  int m_gcnt[3];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_dout[i]   = m_init[i];
        m_glitch[i] = 1'b0;
        m_run[i]    = 0;
        m_glen[i]   = 0;
        m_gcnt[i]   = 0;
      end else begin
        m_glitch[i] = 1'b0;
        if (clr_cnt) m_gcnt[i] = 0;
        if (!en) begin
          m_dout[i] = din;
          m_run[i]  = 0;
        end else if (din != m_dout[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] >= m_delay[i]) begin
            m_dout[i] = din;
            m_run[i]  = 0;
          end
        end else if (m_run[i] > 0) begin
          m_glitch[i] = 1'b1;
          m_glen[i]   = m_run[i];
          m_run[i]    = 0;
          if (m_gcnt[i] < m_gmax[i]) m_gcnt[i] = m_gcnt[i] + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int gcnt_of(input int i);
    if (i == 0) return int'(a_gcnt);
    if (i == 1) return int'(b_gcnt);
    return int'(c_gcnt);
  endfunction

  // scoreboard: every output of every instance against the model each cycle
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("dout[%0d]", i), int'(o_dout[i]), int'(m_dout[i]));
      chk($sformatf("pending[%0d]", i), int'(o_pend[i]), int'(m_run[i] > 0));
      chk($sformatf("dbg_state[%0d]", i), int'(o_dbg[i]), int'(m_run[i] > 0));
      chk($sformatf("glitch[%0d]", i), int'(o_glitch[i]), int'(m_glitch[i]));
      chk($sformatf("glitch_len[%0d]", i), int'(o_glen[i]), m_glen[i]);
      chk($sformatf("glitch_cnt[%0d]", i), gcnt_of(i), m_gcnt[i]);
    end
  end

  // driver: apply din, let one rising edge pass, return just after it
  task automatic cyc(input logic d);
    din = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; din = 1'b0; clr_cnt = 1'b0;
    repeat (3) cyc(1'b0);
    chk("rst dout a", int'(o_dout[0]), 0);
    chk("rst dout c", int'(o_dout[2]), 1);
    chk("rst pending a", int'(o_pend[0]), 0);
    chk("rst glitch_cnt a", int'(a_gcnt), 0);
    rst_n = 1'b1;
    cyc(1'b0);
    chk("c follows 0", int'(o_dout[2]), 0);
    cyc(1'b0);

    // rising step held for 4 samples
    cyc(1'b1);
    chk("step pend1", int'(o_pend[0]), 1);
    chk("step c dout", int'(o_dout[2]), 1);
    cyc(1'b1);
    cyc(1'b1);
    chk("step pend3", int'(o_pend[0]), 1);
    chk("step dout3", int'(o_dout[0]), 0);
    cyc(1'b1);
    chk("step dout4", int'(o_dout[0]), 1);
    chk("step pend4", int'(o_pend[0]), 0);
    chk("step gcnt", int'(a_gcnt), 0);

    // falling pulse of 2 samples is swallowed, then a held fall
    cyc(1'b0);
    cyc(1'b0);
    cyc(1'b1);
    chk("fall glitch", int'(o_glitch[0]), 1);
    chk("fall glen", int'(o_glen[0]), 2);
    chk("fall gcnt", int'(a_gcnt), 1);
    chk("fall dout", int'(o_dout[0]), 1);
    cyc(1'b1);
    chk("fall strobe end", int'(o_glitch[0]), 0);
    repeat (3) cyc(1'b0);
    chk("fall dout3", int'(o_dout[0]), 1);
    cyc(1'b0);
    chk("fall dout4", int'(o_dout[0]), 0);

    // 3-sample high pulse
    repeat (3) cyc(1'b1);
    cyc(1'b0);
    chk("short glitch", int'(o_glitch[0]), 1);
    chk("short glen", int'(o_glen[0]), 3);
    chk("short dout", int'(o_dout[0]), 0);
    chk("short gcnt b", int'(b_gcnt), 2);
    cyc(1'b0);
    chk("short strobe end", int'(o_glitch[0]), 0);
    chk("short glen hold", int'(o_glen[0]), 3);

    // clear, then saturate the 2-bit counter with single-sample pulses
    clr_cnt = 1'b1;
    cyc(1'b0);
    clr_cnt = 1'b0;
    chk("clr gcnt a", int'(a_gcnt), 0);
    for (int k = 1; k <= 5; k++) begin
      cyc(1'b1);
      cyc(1'b0);
      chk("sat gcnt b", int'(b_gcnt), (k < 3) ? k : 3);
      chk("sat glen", int'(o_glen[0]), 1);
    end
    chk("sat gcnt a", int'(a_gcnt), 5);
    cyc(1'b1);
    clr_cnt = 1'b1;
    cyc(1'b0);
    clr_cnt = 1'b0;
    chk("clr+glitch a", int'(a_gcnt), 1);
    chk("clr+glitch b", int'(b_gcnt), 1);

    // bypass: dout is din delayed one edge
    en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(logic'(i % 2));
      chk("byp dout", int'(o_dout[0]), i % 2);
      chk("byp pending", int'(o_pend[0]), 0);
    end
    en = 1'b1;
    cyc(1'b1);
    cyc(1'b0);
    cyc(1'b0);
    chk("midpend pend", int'(o_pend[0]), 1);
    en = 1'b0;
    cyc(1'b0);
    chk("midpend dout", int'(o_dout[0]), 0);
    chk("midpend glitch", int'(o_glitch[0]), 0);
    chk("midpend gcnt", int'(a_gcnt), 1);
    en = 1'b1;
    cyc(1'b0);

    // asynchronous reset while a candidate is being timed
    cyc(1'b1);
    cyc(1'b1);
    chk("ar pend", int'(o_pend[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar dout a", int'(o_dout[0]), 0);
    chk("ar dout c", int'(o_dout[2]), 1);
    chk("ar pending", int'(o_pend[0]), 0);
    chk("ar glen", int'(o_glen[0]), 0);
    chk("ar gcnt", int'(a_gcnt), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) cyc(1'b1);
    chk("ar hold3", int'(o_dout[0]), 0);
    cyc(1'b1);
    chk("ar hold4", int'(o_dout[0]), 1);

    // mixed bursts, scoreboard only
    for (int i = 0; i < 40; i++) begin
      int len;
      len = $urandom_range(1, 5);
      en = ($urandom_range(0, 9) != 0);
      clr_cnt = ($urandom_range(0, 7) == 0);
      for (int j = 0; j < len; j++) cyc(logic'(i % 2));
      clr_cnt = 1'b0;
    end
    en = 1'b1;
    repeat (6) cyc(din);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
